// File: rtl/eth_frame_builder.sv
// eth_frame_builder: streams L2 header, payload and zero pad for one
// scheduler input, then times the post-frame gap before Done.
module eth_frame_builder #(
  parameter int GAP_BYTES = 24,
  parameter int MAX_PLD   = 1500,
  parameter int MIN_PLD   = 46
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MODE,
  input  logic        Start,
  input  logic [47:0] DstMac,
  input  logic [47:0] SrcMac,
  input  logic [15:0] EthType,
  input  logic [10:0] PldLen,
  output logic        PldRd,
  input  logic [7:0]  PldData,
  input  logic        ReqConfirm,
  output logic        ReqOut,
  output logic        ValOut,
  output logic        SoFOut,
  output logic        EoFOut,
  output logic [7:0]  DataOut,
  output logic        Busy,
  output logic        Done,
  output logic        ErrLen
);

  localparam int GW = $clog2(2 * GAP_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE, REQ, HDR, PLD, PAD, GAP
  } state_t;

  state_t        state;
  logic [111:0]  hdrSh;
  logic [10:0]   len;
  logic [10:0]   idx;
  logic [10:0]   lastIdx;
  logic          mode;
  logic          phase;
  logic [GW-1:0] gapCnt;

  logic          strobe;
  logic [10:0]   rdLo;
  logic [10:0]   rdHi;
  logic [10:0]   pldEnd;
  logic [GW-1:0] gapLast;

  assign strobe  = mode | ~phase;
  // Reads lead the byte strobe by two clocks: one for the buffer, one here.
  assign rdLo    = mode ? 11'd12 : 11'd13;
  assign rdHi    = rdLo + len;
  assign pldEnd  = 11'd13 + len;
  assign gapLast = mode ? GW'(GAP_BYTES - 1)
                        : GW'(2 * GAP_BYTES - 1);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      hdrSh   <= '0;
      len     <= '0;
      idx     <= '0;
      lastIdx <= '0;
      mode    <= 1'b0;
      phase   <= 1'b0;
      gapCnt  <= '0;
      PldRd   <= 1'b0;
      ReqOut  <= 1'b0;
      ValOut  <= 1'b0;
      SoFOut  <= 1'b0;
      EoFOut  <= 1'b0;
      DataOut <= 8'h00;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      ErrLen  <= 1'b0;
    end else begin
      ValOut <= 1'b0;
      SoFOut <= 1'b0;
      EoFOut <= 1'b0;
      PldRd  <= 1'b0;
      Done   <= 1'b0;
      ErrLen <= 1'b0;
      phase  <= ~phase;
      unique case (state)
        IDLE: begin
          if (Start && !Done) begin
            if (PldLen > 11'(MAX_PLD)) begin
              ErrLen <= 1'b1;
            end else begin
              hdrSh   <= {DstMac, SrcMac, EthType};
              len     <= PldLen;
              mode    <= MODE;
              lastIdx <= (PldLen < 11'(MIN_PLD))
                         ? 11'(13 + MIN_PLD)
                         : PldLen + 11'd13;
              ReqOut  <= 1'b1;
              Busy    <= 1'b1;
              state   <= REQ;
            end
          end
        end
        REQ: begin
          if (ReqConfirm) begin
            state <= HDR;
            phase <= 1'b0;
            idx   <= '0;
          end
        end
        HDR, PLD, PAD: begin
          if (strobe) begin
            ValOut <= 1'b1;
            SoFOut <= (idx == 11'd0);
            EoFOut <= (idx == lastIdx);
            PldRd  <= (idx >= rdLo) && (idx < rdHi);
            idx    <= idx + 11'd1;
            unique case (1'b1)
              state == HDR: begin
                DataOut <= hdrSh[111:104];
                hdrSh   <= {hdrSh[103:0], 8'h00};
              end
              state == PLD: DataOut <= PldData;
              default:      DataOut <= 8'h00;
            endcase
            if (idx == lastIdx) begin
              state  <= GAP;
              gapCnt <= '0;
            end else if (state == HDR && idx == 11'd13) begin
              state <= (len == 11'd0) ? PAD : PLD;
            end else if (state == PLD && idx == pldEnd) begin
              state <= PAD;
            end
          end
        end
        GAP: begin
          ReqOut <= 1'b0;
          gapCnt <= gapCnt + 1'b1;
          if (gapCnt == gapLast) begin
            Done  <= 1'b1;
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_frame_builder.sv
// tb_eth_frame_builder: random frames checked against a byte-list
// frame model, plus grant delay, length limit, back-to-back and reset.
module tb_eth_frame_builder;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        MODE = 1'b0;
  logic        Start = 1'b0;
  logic [47:0] DstMac = '0;
  logic [47:0] SrcMac = '0;
  logic [15:0] EthType = '0;
  logic [10:0] PldLen = '0;
  logic        PldRd;
  logic [7:0]  PldData = 8'h00;
  logic        ReqConfirm = 1'b0;
  logic        ReqOut;
  logic        ValOut;
  logic        SoFOut;
  logic        EoFOut;
  logic [7:0]  DataOut;
  logic        Busy;
  logic        Done;
  logic        ErrLen;

  int nChk = 0;
  int nPass = 0;

  logic [7:0] pbuf [0:2047];
  int         rdPtr = 0;
  logic       clrPtr = 1'b0;

  eth_frame_builder dut (
    .Clk(Clk), .Rst(Rst), .MODE(MODE), .Start(Start),
    .DstMac(DstMac), .SrcMac(SrcMac), .EthType(EthType),
    .PldLen(PldLen), .PldRd(PldRd), .PldData(PldData),
    .ReqConfirm(ReqConfirm), .ReqOut(ReqOut), .ValOut(ValOut),
    .SoFOut(SoFOut), .EoFOut(EoFOut), .DataOut(DataOut),
    .Busy(Busy), .Done(Done), .ErrLen(ErrLen)
  );

  always #5 Clk = ~Clk;

  // payload buffer: data appears the clock after a read strobe
  always @(posedge Clk) begin
    if (clrPtr) begin
      rdPtr <= 0;
    end else if (PldRd) begin
      PldData <= pbuf[rdPtr];
      rdPtr   <= rdPtr + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nChk++;
    if (obs !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else
      nPass++;
  endtask

  function automatic logic [15:0] outs();
    return {PldRd, ReqOut, ValOut, SoFOut, EoFOut,
            DataOut, Busy, Done, ErrLen};
  endfunction

  task automatic runFrame(input bit md, input int len, input int gDly,
                          input bit seqPld, input bit midStart,
                          input bit doneStart, input bit noWait,
                          input int rstAt);
    logic [47:0] dst, src;
    logic [15:0] et;
    logic [7:0]  exp[$];
    logic [7:0]  got[$];
    int k, firstK, lastK, eofK, doneK, reqFallK;
    int sofCnt, sofPos, eofCnt, eofPos, rdCnt;
    int stepBad, reqBad, bad, step;
    bit doneSeen, busyEof, wasRst;
    firstK = -1; lastK = 0; eofK = 0; doneK = 0; reqFallK = -1;
    sofCnt = 0; sofPos = -1; eofCnt = 0; eofPos = -1; rdCnt = 0;
    stepBad = 0; reqBad = 0; bad = 0;
    doneSeen = 0; busyEof = 0; wasRst = 0;
    step = md ? 1 : 2;
    if (seqPld) begin
      dst = 48'h0102_0304_0506;
      src = 48'h0A0B_0C0D_0E0F;
      et  = 16'h0800;
    end else begin
      dst = {16'($urandom()), 32'($urandom())};
      src = {16'($urandom()), 32'($urandom())};
      et  = 16'($urandom());
    end
    for (int i = 0; i < len; i++)
      pbuf[i] = seqPld ? 8'(8'h80 + i) : 8'($urandom());
    // reference frame: header, payload, zero pad to a 60-byte frame
    for (int i = 0; i < 6; i++) exp.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) exp.push_back(src[47-8*i -: 8]);
    exp.push_back(et[15:8]);
    exp.push_back(et[7:0]);
    for (int i = 0; i < len; i++) exp.push_back(pbuf[i]);
    while (exp.size() < 60) exp.push_back(8'h00);

    if (!noWait) begin
      @(posedge Clk); #1;
    end
    MODE = md; DstMac = dst; SrcMac = src; EthType = et;
    PldLen = 11'(len); Start = 1'b1; clrPtr = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; clrPtr = 1'b0;
    MODE = 1'($urandom()); DstMac = ~dst;
    PldLen = 11'($urandom_range(0, 60));
    k = 0;
    while (!doneSeen && !wasRst && k < 6000) begin
      if (k < gDly && (ReqOut !== 1'b1 || ValOut !== 1'b0)) reqBad++;
      if (PldRd) rdCnt++;
      if (ValOut) begin
        if (got.size() == 0) firstK = k;
        else if (k - lastK != step) stepBad++;
        if (SoFOut) begin sofCnt++; sofPos = got.size(); end
        if (EoFOut) begin
          eofCnt++; eofPos = got.size(); eofK = k; busyEof = Busy;
        end
        lastK = k;
        got.push_back(DataOut);
      end
      if (eofCnt > 0 && !ReqOut && reqFallK < 0) reqFallK = k;
      if (Done) begin doneSeen = 1; doneK = k; end
      ReqConfirm = (k >= gDly) && (k < gDly + 4);
      Start = (midStart && k == gDly + 40) || (doneStart && doneSeen);
      if (rstAt > 0 && got.size() == rstAt) begin
        Rst = 1'b1;
        #1;
        chk("rst_outs", outs(), 16'h0);
        wasRst = 1;
      end else if (!doneSeen) begin
        @(posedge Clk); #1;
        k++;
      end
    end
    ReqConfirm = 1'b0;
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (got[i] !== exp[i]) bad++;
    chk("bytes_bad", bad, 0);
    if (wasRst) begin
      chk("rst_eof", eofCnt, 0);
      Start = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_hold", outs(), 16'h0);
      Rst = 1'b0;
    end else begin
      chk("done_seen", doneSeen, 1);
      chk("frame_len", got.size(), exp.size());
      chk("sof_cnt", sofCnt, 1);
      chk("sof_pos", sofPos, 0);
      chk("eof_cnt", eofCnt, 1);
      chk("eof_pos", eofPos, exp.size() - 1);
      chk("pldrd_cnt", rdCnt, len);
      chk("grant_lat", firstK - gDly, 2);
      chk("byte_step", stepBad, 0);
      chk("done_gap", doneK - eofK, 24 * step);
      chk("req_fall", reqFallK - eofK, 1);
      chk("busy_eof", busyEof, 1);
      if (gDly > 0) chk("req_wait", reqBad, 0);
      @(posedge Clk); #1;
      Start = 1'b0;
      chk("idle_after", {Busy, ReqOut}, 2'b00);
    end
  endtask

  task automatic errLen(input int len);
    @(posedge Clk); #1;
    PldLen = 11'(len);
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    chk("errlen", ErrLen, 1'b1);
    chk("errlen_idle", {Busy, ReqOut}, 2'b00);
    @(posedge Clk); #1;
    chk("errlen_pulse", ErrLen, 1'b0);
  endtask

  initial begin
    #2 Rst = 1'b1;
    #2 chk("reset_outs", outs(), 16'h0);
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    runFrame(1'b1, 10, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    runFrame(1'b0, 10, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    runFrame(1'($urandom()), 30, 50, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    runFrame(1'b1, 1500, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    errLen(1501);
    errLen(2047);
    runFrame(1'b0, 20, 2, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    runFrame(1'b1, 46, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    runFrame(1'b1, 40, 0, 1'b0, 1'b0, 1'b0, 1'b0, 34);
    runFrame(1'b0, 40, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int f = 0; f < 8; f++) begin
      int ln;
      int pick;
      pick = $urandom_range(0, 5);
      unique case (pick)
        0: ln = 0;
        1: ln = 1;
        2: ln = 45;
        3: ln = 46;
        4: ln = 47;
        default: ln = $urandom_range(48, 200);
      endcase
      runFrame(1'($urandom()), ln, $urandom_range(0, 5),
               1'b0, 1'b0, 1'b0, 1'b0, 0);
    end
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule

// File: doc/eth_frame_builder.md
Name: eth_frame_builder

Overview:
- Upstream frame source for the L2 transmit path: turns a payload buffer plus MAC/EtherType fields into a byte stream for one scheduler input (Val/SoF/EoF/Req/Data plus its ReqConfirm grant).
- Prepends the 14-byte L2 header, zero-pads the payload to the 46-byte minimum, and enforces an inter-frame gap.
- Emits no preamble and no CRC; the downstream output stage adds both.

Parameters:
- GAP_BYTES, 24, byte-times of idle after EoF before Done (4 CRC + 8 preamble + 12 IPG).
- MAX_PLD, 1500, largest accepted PldLen.
- MIN_PLD, 46, payload is zero-padded up to this length.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  async active-high reset.
- MODE  in  1  0: one byte per 2 clocks (nibble link); 1: one byte per clock.
- Start  in  1  single-cycle frame request.
- DstMac  in  48  destination MAC, sampled on accepted Start.
- SrcMac  in  48  source MAC, sampled on accepted Start.
- EthType  in  16  EtherType/length, sampled on accepted Start.
- PldLen  in  11  payload byte count (0..MAX_PLD), sampled on Start.
- PldRd  out  1  payload read strobe; PldData valid the following clock.
- PldData  in  8  payload byte from buffer.
- ReqConfirm  in  1  grant from the scheduler.
- ReqOut  out  1  transmit request to the scheduler.
- ValOut  out  1  byte valid.
- SoFOut  out  1  first byte of frame, qualified by ValOut.
- EoFOut  out  1  last byte of frame, qualified by ValOut.
- DataOut  out  8  frame byte.
- Busy  out  1  frame in progress (REQ through GAP).
- Done  out  1  one-cycle pulse at end of GAP.
- ErrLen  out  1  one-cycle pulse when Start is rejected for PldLen>MAX_PLD.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, phase 0. Reset acts immediately at any point; a frame cut off mid-stream gets no EoF.
- Outputs are registered.
- FSM states: IDLE, REQ, HDR, PLD, PAD, GAP.
- IDLE:
  - Start with PldLen<=MAX_PLD: latch the fields and MODE, set ReqOut=1, set Busy=1, go to REQ.
  - Start with PldLen>MAX_PLD: ErrLen pulses the next clock; stay in IDLE.
  - Start while not in IDLE is ignored.
- REQ: hold ReqOut until ReqConfirm is sampled high, then go to HDR. The first ValOut appears 2 clocks after the grant edge.
- Byte strobe:
  - MODE=1: every clock.
  - MODE=0: a phase bit, cleared on entry to HDR, toggles each clock; a byte is emitted on phase=0 clocks only. ValOut is low on the alternate clocks, with DataOut held.
  - MODE is latched at Start and ignored mid-frame.
- HDR, 14 bytes, MSB byte first: DstMac[47:40]..DstMac[7:0], SrcMac[47:40]..SrcMac[7:0], EthType[15:8], EthType[7:0]. SoFOut=1 on header byte 0 only.
- PLD: emits PldLen bytes.
  - PldRd is high exactly one clock before each payload-byte strobe clock, so exactly PldLen PldRd pulses are issued.
  - The first PldRd falls during the clock before the strobe of the first payload byte (frame byte 14).
  - PldLen=0 skips PLD entirely.
- PAD: emits max(0, MIN_PLD−PldLen) bytes of 0x00.
- Frame length is 14+max(PldLen,MIN_PLD), i.e. 60..1514 bytes. EoFOut=1 on the last byte, which may come from PLD or PAD.
- ReqOut stays high through the EoF byte and drops the clock after it.
- ReqConfirm deasserting mid-frame is ignored; the frame always completes.
- GAP:
  - Counts GAP_BYTES byte-times: GAP_BYTES clocks in MODE=1, 2·GAP_BYTES clocks in MODE=0.
  - At the end of the count, Done pulses one clock, Busy drops, and the FSM returns to IDLE.
  - Start arriving in the same clock as Done is ignored; the earliest accepted Start is the clock after Done.
- Counter widths:
  - Byte counter is 11 bits.
  - Gap counter holds 2·GAP_BYTES.

Test Plan:
- MODE=1, PldLen=10, DstMac=0x0102_0304_0506, SrcMac=0x0A0B_0C0D_0E0F, EthType=0x0800, grant immediate, buffer bytes 0x80..0x89 -> 60 contiguous ValOut clocks; bytes 0..13 = 01..06,0A..0F,08,00; bytes 14..23 = 80..89; bytes 24..59 = 00; SoF on byte 0, EoF on byte 59; 10 PldRd pulses; Done 24 clocks after EoF.
- Same frame in MODE=0 -> ValOut on alternate clocks across 119 clocks with identical byte sequence; Done 48 clocks after EoF.
- ReqConfirm held low 50 clocks after Start -> ReqOut=1, ValOut=0 throughout; grant asserted -> SoF byte exactly 2 clocks later.
- PldLen=1500 MODE=1 -> 1514 bytes, no PAD bytes, EoF on last payload byte, 1500 PldRd; PldLen=1501 -> ErrLen pulse, Busy stays 0, ReqOut stays 0.
- Back-to-back: second Start mid-frame ignored; Start in Done clock ignored; Start one clock after Done accepted and runs a normal frame.
- Rst asserted at payload byte 20 -> all outputs 0 asynchronously, no EoF; after release, a new Start produces a correct complete frame.
